// File: rtl/rs_syndrome_ctrl.sv
// rs_syndrome_ctrl: RS(15,11) syndrome sequencer, S1..S4 by Horner's rule on one shared GF(16) multiplier
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     : symbol handshake, in_sym = r_i (r14 first)
//   abort                 : synchronous flush of the codeword in progress
//   syn1..syn4, err_free  : syndromes and all-zero flag, qualified by syn_valid
//   syn_valid/syn_ack     : result held until acknowledged
//   sym_cnt               : symbols accepted in the current codeword

module full_GF_mult (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] out
);
    logic [3:0] a_sh;
    always_comb begin
        out  = '0;
        a_sh = A;
        for (int i = 0; i < 4; i++) begin
            out  = B[i] ? out ^ a_sh : out;
            // multiply by x, reducing x^4 to x+1
            a_sh = {a_sh[2:0], 1'b0} ^ {2'b00, a_sh[3], a_sh[3]};
        end
    end
endmodule

module rs_syndrome_ctrl #(
    parameter int N_SYM = 15,
    parameter int N_SYN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [3:0] in_sym,
    output logic       in_ready,
    input  logic       abort,
    output logic [3:0] syn1,
    output logic [3:0] syn2,
    output logic [3:0] syn3,
    output logic [3:0] syn4,
    output logic       syn_valid,
    output logic       err_free,
    input  logic       syn_ack,
    output logic [3:0] sym_cnt
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam logic [3:0] LAST = 4'(N_SYM);

    state_t     state;
    logic [3:0] s [N_SYN];
    logic [1:0] idx;
    logic [3:0] sym_reg;
    logic [3:0] alpha;
    logic [3:0] prod;
    logic [3:0] s_new;
    logic [3:0] cnt_inc;

    assign alpha   = idx == 2'd0 ? 4'h2 : idx == 2'd1 ? 4'h4 : idx == 2'd2 ? 4'h8 : 4'h3;
    assign s_new   = prod ^ sym_reg;
    assign cnt_inc = sym_cnt + 4'd1;
    assign syn1    = s[0];
    assign syn2    = s[1];
    assign syn3    = s[2];
    assign syn4    = s[3];

    full_GF_mult u_mult (.A(s[idx]), .B(alpha), .out(prod));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '{default: 4'h0};
            sym_cnt   <= '0;
            idx       <= '0;
            sym_reg   <= '0;
            syn_valid <= 1'b0;
            err_free  <= 1'b0;
            in_ready  <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            s         <= '{default: 4'h0};
            sym_cnt   <= '0;
            idx       <= '0;
            syn_valid <= 1'b0;
            err_free  <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= ~(in_valid & in_ready);
                    if (in_valid && in_ready) begin
                        sym_reg <= in_sym;
                        idx     <= '0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    s[idx] <= s_new;
                    idx    <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        sym_cnt <= cnt_inc;
                        if (cnt_inc == LAST) begin
                            state     <= DONE;
                            syn_valid <= 1'b1;
                            // S4 is being written this cycle, so use its new value
                            err_free  <= ~|{s[0], s[1], s[2], s_new};
                        end else begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (syn_ack) begin
                        s         <= '{default: 4'h0};
                        sym_cnt   <= '0;
                        syn_valid <= 1'b0;
                        err_free  <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// tb_rs_syndrome_ctrl: scoreboard bench for rs_syndrome_ctrl against a log/antilog GF(16) syndrome model
module tb_rs_syndrome_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_sym = 4'h0;
    logic       abort = 1'b0;
    logic       syn_ack = 1'b0;
    logic       in_ready;
    logic [3:0] syn1, syn2, syn3, syn4;
    logic       syn_valid;
    logic       err_free;
    logic [3:0] sym_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc = 0;
    logic [16:0] exp_q[$];
    logic [16:0] mon_e;
    logic        seen = 1'b0;
    logic [3:0]  gexp [15];
    logic [3:0]  glog [16];
    logic [3:0]  cw [15];

    rs_syndrome_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym), .in_ready(in_ready),
        .abort(abort), .syn1(syn1), .syn2(syn2), .syn3(syn3), .syn4(syn4),
        .syn_valid(syn_valid), .err_free(err_free), .syn_ack(syn_ack), .sym_cnt(sym_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return gexp[4'((int'(glog[a]) + int'(glog[b])) % 15)];
    endfunction

    // S_j = sum over i of r_i * alpha^(j*i)
    function automatic logic [16:0] model();
        logic [15:0] sv;
        sv = '0;
        for (int j = 1; j <= 4; j++) begin
            logic [3:0] acc;
            acc = 4'h0;
            for (int i = 0; i < 15; i++) acc ^= gmul(cw[i], gexp[4'((j * i) % 15)]);
            sv[16 - 4 * j +: 4] = acc;
        end
        return {sv, sv == 16'h0};
    endfunction

    always @(posedge clk) begin
        #1;
        if (syn_valid && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual %0h expected none", {syn1, syn2, syn3, syn4, err_free});
            end else begin
                mon_e = exp_q.pop_front();
                chk("syndromes", {syn1, syn2, syn3, syn4, err_free}, mon_e);
            end
        end else if (!syn_valid) seen = 1'b0;
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", 17'(in_ready), 17'd1);
    endtask

    task automatic send_sym(input logic [3:0] v);
        wait_ready();
        in_valid = 1'b1;
        in_sym = v;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cw();
        send_sym(cw[14]);
        first_acc = cyc;
        for (int i = 13; i >= 0; i--) send_sym(cw[i]);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!syn_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_timeout", 17'(syn_valid), 17'd1);
    endtask

    task automatic do_ack();
        syn_ack = 1'b1;
        @(posedge clk); #1;
        syn_ack = 1'b0;
        chk("ack_valid", 17'(syn_valid), 17'd0);
        chk("ack_cnt", 17'(sym_cnt), 17'd0);
    endtask

    task automatic set_err(input int pos, input logic [3:0] v);
        for (int i = 0; i < 15; i++) cw[i] = 4'h0;
        cw[pos] = v;
    endtask

    task automatic rand_cw(input bit full);
        for (int i = 0; i < 15; i++) cw[i] = full ? 4'($urandom_range(15, 0)) : 4'h0;
        if (!full) begin
            cw[$urandom_range(14, 0)] = 4'($urandom_range(15, 1));
            cw[$urandom_range(14, 0)] = 4'($urandom_range(15, 1));
        end
    endtask

    task automatic chk_cleared(input string name);
        chk({name, "_syn"}, {1'b0, syn1, syn2, syn3, syn4}, 17'd0);
        chk({name, "_cnt"}, 17'(sym_cnt), 17'd0);
        chk({name, "_valid"}, 17'(syn_valid), 17'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        gexp[0] = 4'h1;
        glog[1] = 4'd0;
        glog[0] = 4'd0;
        for (int k = 1; k < 15; k++) begin
            gexp[k] = {gexp[k-1][2:0], 1'b0} ^ (gexp[k-1][3] ? 4'h3 : 4'h0);
            glog[gexp[k]] = 4'(k);
        end

        #2;
        chk_cleared("reset");
        chk("reset_ready", 17'(in_ready), 17'd0);
        chk("reset_errfree", 17'(err_free), 17'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 17'(in_ready), 17'd1);

        // all-zero codeword and latency
        set_err(0, 4'h0);
        exp_q.push_back({16'h0000, 1'b1});
        send_cw();
        wait_valid();
        chk("latency", 17'(cyc - first_acc + 1), 17'd75);
        chk("done_cnt", 17'(sym_cnt), 17'd15);
        do_ack();

        set_err(0, 4'h1);
        exp_q.push_back({16'h1111, 1'b0});
        send_cw(); wait_valid(); do_ack();

        set_err(1, 4'h1);
        exp_q.push_back({16'h2483, 1'b0});
        send_cw(); wait_valid(); do_ack();

        // held result while unacknowledged
        set_err(1, 4'h3);
        exp_q.push_back({16'h6cb5, 1'b0});
        send_cw(); wait_valid();
        for (int k = 0; k < 20; k++) begin
            chk("hold_syn", {1'b0, syn1, syn2, syn3, syn4}, 17'h06cb5);
            chk("hold_valid", 17'(syn_valid), 17'd1);
            chk("hold_ready", 17'(in_ready), 17'd0);
            @(posedge clk); #1;
        end
        do_ack();

        // in_valid held high: one accept per 5 cycles
        rand_cw(1'b1);
        exp_q.push_back(model());
        wait_ready();
        for (int c = 0; c < 75; c++) begin
            in_valid = 1'b1;
            in_sym = cw[14 - c / 5];
            chk("bp_ready", 17'(in_ready), 17'(c % 5 == 0));
            chk("bp_cnt", 17'(sym_cnt), 17'(c / 5));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_valid", 17'(syn_valid), 17'd1);
        chk("bp_cnt_final", 17'(sym_cnt), 17'd15);
        do_ack();

        // ack in the cycle syn_valid rises must be ignored
        rand_cw(1'b0);
        exp_q.push_back(model());
        send_cw();
        repeat (3) begin @(posedge clk); #1; end
        syn_ack = 1'b1;
        @(posedge clk); #1;
        syn_ack = 1'b0;
        chk("early_ack_valid", 17'(syn_valid), 17'd1);
        @(posedge clk); #1;
        chk("early_ack_hold", 17'(syn_valid), 17'd1);
        do_ack();

        // abort after 7 symbols, offered symbol not taken
        rand_cw(1'b1);
        for (int i = 14; i >= 8; i--) send_sym(cw[i]);
        wait_ready();
        chk("pre_abort_cnt", 17'(sym_cnt), 17'd7);
        in_valid = 1'b1;
        in_sym = 4'h9;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        in_valid = 1'b0;
        chk_cleared("abort");
        chk("abort_ready", 17'(in_ready), 17'd1);
        set_err(0, 4'h0);
        exp_q.push_back({16'h0000, 1'b1});
        send_cw(); wait_valid(); do_ack();

        // asynchronous reset in the middle of ACC
        rand_cw(1'b1);
        for (int i = 14; i >= 10; i--) send_sym(cw[i]);
        #3 rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        chk("async_rst_ready", 17'(in_ready), 17'd0);
        chk("async_rst_errfree", 17'(err_free), 17'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        set_err(0, 4'h0);
        exp_q.push_back({16'h0000, 1'b1});
        send_cw(); wait_valid(); do_ack();

        // abort together with syn_ack in DONE
        rand_cw(1'b1);
        exp_q.push_back(model());
        send_cw(); wait_valid();
        abort = 1'b1;
        syn_ack = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        syn_ack = 1'b0;
        chk_cleared("abort_ack");
        chk("abort_ack_ready", 17'(in_ready), 17'd1);

        for (int k = 0; k < 6; k++) begin
            rand_cw(k[0]);
            exp_q.push_back(model());
            send_cw(); wait_valid(); do_ack();
        end

        @(posedge clk); #2;
        chk("queue_empty", 17'(exp_q.size()), 17'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
